dm_responder: RTL

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, commits the access to a word-organised RAM, and returns a response with read data and an error flag. It sits opposite the CPU datapath's load/store initiator and is the memory end for the multi-cycle and pipelined cores, replacing the zero-latency data memory.

---
 rtl/dm_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with programmable wait states,
// byte-enabled stores into a word RAM and a per-store write-log strobe.
module dm_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_be,
   input  logic [31:0] i_req_pc,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_log_valid,
   output logic [31:0] o_log_pc,
   output logic [31:0] o_log_addr,
   output logic [31:0] o_log_data
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = WAIT_CYCLES < 2 ? 1 : $clog2(WAIT_CYCLES);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic r_write, r_err, r_log_valid, w_idle, w_accept, w_commit, w_write, w_err;
   logic [31:0] r_addr, r_wdata, r_pc, r_rdata, r_log_pc, r_log_addr, r_log_data;
   logic [31:0] w_addr, w_wdata, w_pc, w_old, w_merged;
   logic [3:0] r_be, w_be;
   logic [AW-1:0] w_idx;
   logic [31:0] r_mem [DEPTH_WORDS];
   assign w_idle = r_state == S_IDLE;
   assign w_accept = w_idle && i_req_valid;
   // with zero wait states the commit happens on the accept edge, straight from the inputs
   assign w_write = w_idle ? i_req_write : r_write;
   assign w_addr = w_idle ? i_req_addr : r_addr;
   assign w_wdata = w_idle ? i_req_wdata : r_wdata;
   assign w_be = w_idle ? i_req_be : r_be;
   assign w_pc = w_idle ? i_req_pc : r_pc;
   assign w_err = (w_addr[1:0] != 2'b00) || (w_addr >= 32'(DEPTH_WORDS * 4));
   assign w_idx = w_addr[AW+1:2];
   assign w_old = r_mem[w_idx];
   genvar b;
   for (b = 0; b < 4; b++) begin : g_lane
      assign w_merged[8*b +: 8] = w_be[b] ? w_wdata[8*b +: 8] : w_old[8*b +: 8];
   end
   always_comb begin
      w_next = r_state;
      w_commit = 1'b0;
      case (r_state)
         S_IDLE: if (i_req_valid) begin
            w_next = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
            w_commit = WAIT_CYCLES == 0;
         end
         S_WAIT: if (r_cnt == '0) begin
            w_next = S_RESP;
            w_commit = 1'b1;
         end
         S_RESP: if (i_rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) r_state <= i_reset ? S_IDLE : w_next;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
         r_cnt <= '0;
         r_write <= 1'b0;
         r_addr <= '0;
         r_wdata <= '0;
         r_be <= '0;
         r_pc <= '0;
         r_rdata <= '0;
         r_err <= 1'b0;
         r_log_valid <= 1'b0;
         r_log_pc <= '0;
         r_log_addr <= '0;
         r_log_data <= '0;
      end else begin
         r_log_valid <= 1'b0;
         if (w_accept) begin
            r_write <= i_req_write;
            r_addr <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_be <= i_req_be;
            r_pc <= i_req_pc;
            r_cnt <= CW'(WAIT_CYCLES - 1);
         end else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
         if (w_commit) begin
            r_err <= w_err;
            r_rdata <= (w_err || w_write) ? '0 : w_old;
            if (!w_err && w_write) begin
               r_mem[w_idx] <= w_merged;
               r_log_valid <= 1'b1;
               r_log_pc <= w_pc;
               r_log_addr <= {w_addr[31:2], 2'b00};
               r_log_data <= w_merged;
            end
         end
         if (r_state == S_RESP && i_rsp_ready) begin
            r_rdata <= '0;
            r_err <= 1'b0;
         end
      end
   end
   assign o_req_ready = w_idle && !i_reset;
   assign o_rsp_valid = r_state == S_RESP;
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_err = r_err;
   assign o_log_valid = r_log_valid;
   assign o_log_pc = r_log_pc;
   assign o_log_addr = r_log_addr;
   assign o_log_data = r_log_data;
endmodule
